// File: rtl/reg_bank_b3_pkg.sv
// Shared types and the per-bit register operation for reg_bank_b3.
package reg_bank_b3_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_SET    = 2'd1,
    OP_CLEAR  = 2'd2,
    OP_TOGGLE = 2'd3
  } reg_op_t;

  // Ops are purely bitwise, so one bit of a lane is computed at a time.
  function automatic logic apply_op(input reg_op_t op, input logic old, input logic data);
    logic res;
    case (op)
      OP_WRITE:  res = data;
      OP_SET:    res = old | data;
      OP_CLEAR:  res = old & ~data;
      OP_TOGGLE: res = old ^ data;
      default:   res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_b3_cell.sv
// One read/write register: byte-lane selected write/set/clear/toggle, sync active-low reset.
module reg_bank_b3_cell
  import reg_bank_b3_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            SELECT_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0]  RESET_PAT    = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  reg_op_t                 op_i,
  input  logic [SELECT_WIDTH-1:0] sel_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   value_o
);

  localparam int unsigned LANE_W = DATA_WIDTH / SELECT_WIDTH;

  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] value_d;

  for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_bit
    assign value_d[b] = (we_i && sel_i[b / LANE_W]) ? apply_op(op_i, value_q[b], data_i[b])
                                                    : value_q[b];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) value_q <= RESET_PAT;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/reg_bank_b3.sv
// Wishbone B3 classic register bank with write/set/clear/toggle aliases and RO hw inputs.
// Optional write lock input enabled by defining REG_BANK_B3_LOCK_EN.
module reg_bank_b3
  import reg_bank_b3_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           SELECT_WIDTH = 4,
  parameter int unsigned           NUM_REGS     = 8,
  parameter int unsigned           ADDR_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_PAT    = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK      = '0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cycle,
  input  logic                           strobe,
  input  logic                           writeEnable,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic [SELECT_WIDTH-1:0]        select,
  input  logic [DATA_WIDTH-1:0]          dataMaster,
  output logic [DATA_WIDTH-1:0]          dataSlave,
  output logic                           ack,
  output logic                           err,
  output logic                           rty,
`ifdef REG_BANK_B3_LOCK_EN
  input  logic                           lock,
`endif
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            write_pulse
);

  localparam int unsigned IW    = ADDR_WIDTH - 2;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW:0] NREGS = (IW+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [IW-1:0]         idx;
  logic [IDX_W-1:0]      idx_s;
  logic                  accept;
  logic                  in_range;
  logic                  is_ro;
  logic                  locked;
  logic                  err_now;
  logic                  wr_commit;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  ack_q,   ack_d;
  logic                  err_q,   err_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;

  assign idx   = address[ADDR_WIDTH-1:2];
  assign idx_s = idx[IDX_W-1:0];

  always_comb begin
    accept   = cycle & strobe & ~(ack_q | err_q);
    in_range = ({1'b0, idx} < NREGS);
    is_ro    = in_range & RO_MASK[idx_s];
`ifdef REG_BANK_B3_LOCK_EN
    locked   = lock & ~is_ro;
`else
    locked   = 1'b0;
`endif
    err_now   = ~in_range | (writeEnable & (is_ro | locked));
    wr_commit = accept & writeEnable & ~err_now;
    rdata     = in_range ? regs[idx_s] : '0;

    ack_d   = accept & ~err_now;
    err_d   = accept & err_now;
    data_d  = data_q;
    pulse_d = '0;
    if (accept) data_d = (!writeEnable && !err_now) ? rdata : '0;
    if (wr_commit) pulse_d = NUM_REGS'(1) << idx_s;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      pulse_q <= '0;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign regs[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_rw
      reg_bank_b3_cell #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SELECT_WIDTH (SELECT_WIDTH),
        .RESET_PAT    (RESET_PAT)
      ) u_cell (
        .clk_i   (clock),
        .rst_ni  (reset),
        .we_i    (wr_commit && (idx_s == IDX_W'(i))),
        .op_i    (reg_op_t'(address[1:0])),
        .sel_i   (select),
        .data_i  (dataMaster),
        .value_o (regs[i])
      );
    end
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // hw_in slices behind RW registers are intentionally ignored.
  logic unused_hw;
  assign unused_hw = ^hw_in;

  assign dataSlave   = data_q;
  assign ack         = ack_q;
  assign err         = err_q;
  assign rty         = 1'b0;
  assign write_pulse = pulse_q;

endmodule

// File: doc/reg_bank_b3.md
Name: reg_bank_b3

Overview:
Parametrised Wishbone B3 classic slave holding NUM_REGS control/status registers. Each register has four aliases: write, set, clear and toggle. Registered ack/err give one-cycle latency. Read-only registers reflect hardware inputs, and every accepted write produces a per-register strobe. Used as the generic peripheral register file behind the system Wishbone interconnect.

Parameters:
DATA_WIDTH, 32, register and bus data width; must be a multiple of SELECT_WIDTH
SELECT_WIDTH, 4, number of byte-lane selects; lane width is DATA_WIDTH/SELECT_WIDTH
NUM_REGS, 8, number of registers (1..64)
ADDR_WIDTH, 8, word-address width; must satisfy ADDR_WIDTH >= 2+clog2(NUM_REGS)
RESET_PAT, 0, reset value of every read/write register
RO_MASK, 0, NUM_REGS-bit map; bit i set means register i is read-only and sourced from hw_in

Ports:
clock  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
cycle  in  1  Wishbone CYC_I
strobe  in  1  Wishbone STB_I
writeEnable  in  1  Wishbone WE_I
address  in  ADDR_WIDTH  word address: [1:0] is the op, [ADDR_WIDTH-1:2] is the register index
select  in  SELECT_WIDTH  byte-lane enables
dataMaster  in  DATA_WIDTH  write data
dataSlave  out  DATA_WIDTH  read data, registered
ack  out  1  registered acknowledge
err  out  1  registered error
rty  out  1  tied 0
hw_in  in  NUM_REGS*DATA_WIDTH  read value for read-only registers; register i occupies slice i
regs_out  out  NUM_REGS*DATA_WIDTH  current register values, flattened
write_pulse  out  NUM_REGS  one-cycle strobe per register on each accepted write

Behaviour:
- Reset (reset==0 at a rising edge): every read/write register takes RESET_PAT. ack, err, dataSlave and write_pulse all go to 0. An in-flight request is dropped with no response; the master retries. Reset overrides any simultaneous request.
- Request accept: on a rising edge with cycle&strobe=1 and ack|err=0. The response (ack or err) is asserted on that edge and held for exactly one cycle. It then deasserts for at least one cycle, so a held strobe is answered every other cycle.
- Decode: idx = address[ADDR_WIDTH-1:2].
  - err when idx >= NUM_REGS (read or write).
  - err on a write to an RO register.
  - `ifdef lock case per Optional Feature.
  - Otherwise ack.
- Reads:
  - dataSlave is loaded on the accepting edge with regs[idx] (RW register) or hw_in slice (RO register). hw_in is sampled at that edge.
  - The op bits are ignored on reads.
  - On err, dataSlave is 0.
- Writes, per lane k where select[k]=1 (lanes with select[k]=0 are unchanged):
  - op 0 (write): new = dataMaster
  - op 1 (set): new = old | dataMaster
  - op 2 (clear): new = old & ~dataMaster
  - op 3 (toggle): new = old ^ dataMaster
- Write commit: the register updates on the accepting edge, so regs_out reflects the new value in the cycle ack is high.
- write_pulse[idx]: pulses for one cycle, coincident with ack, on every acked write, including select=0 writes.
- select=0 write: acked; register unchanged.
- cycle dropped while ack/err is high: no effect. Strobe without cycle is ignored.
- RO slices of regs_out mirror hw_in combinationally.

Optional Feature:
Macro REG_BANK_B3_LOCK_EN.
- Defined: adds input port `lock` (1 bit). While lock==1 at the accepting edge, writes to RW registers return err with no update and no write_pulse. Reads are unaffected.
- Undefined: the port is absent and writes are never locked.

Decomposition:
- Package reg_bank_b3_pkg holds:
  - typedef enum logic[1:0] reg_op_t {OP_WRITE=0, OP_SET=1, OP_CLEAR=2, OP_TOGGLE=3}
  - function apply_op(op, old, data) returning the lane result
- Sub-module reg_bank_b3_cell: one DATA_WIDTH register with per-lane select, op apply, synchronous reset to RESET_PAT, and a write-enable input. It is instantiated by generate only for RW indices.
- The top level owns decode, ack/err/dataSlave registers and write_pulse.

Test Plan:
1. Reset low for 2 cycles, then read idx 0..7 -> ack on each accept; all RW registers read 0x00000000; err=0.
2. Write 0xA5A5_00FF to idx 2 (op 0, select 4'hF); set 0x0000_FF00 (op 1); clear 0x0000_000F (op 2); toggle 0xFFFF_0000 (op 3); then read idx 2. Expect values 0xA5A5_00FF, 0xA5A5_FFFF, 0xA5A5_FFF0, 0x5A5A_FFF0. write_pulse[2] fires on each write.
3. Write 0x1122_3344 to idx 1 with select 4'b0101 (prior value 0) -> 0x0022_0044. Repeat with select 4'b0000 -> unchanged, ack=1, write_pulse[1]=1.
4. With RO_MASK=8'h10 and hw_in slice 4 = 0xDEAD_BEEF: read idx 4 -> 0xDEAD_BEEF with ack. Write idx 4 -> err=1, ack=0, value unchanged.
5. Read idx 9 (NUM_REGS=8) -> err one cycle, dataSlave=0. Hold strobe continuously -> responses on alternate cycles only.
6. Assert reset low in the same cycle as a write of 0xFFFF_FFFF to idx 3 -> no ack, register = RESET_PAT. With REG_BANK_B3_LOCK_EN defined and lock=1, write idx 0 -> err, no change; read idx 0 -> ack.
